pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage MIPS pipeline (fetch/decode/execute/memory/wback).
//  Watches the four stage IRs and the jump/beq resolution flags, and drives PC enable,
//  IF/ID hold, execute bubble insertion, decode/execute flush and ALU operand forwarding.
//  Replaces the ad-hoc halt flag: owns the reset-restart and post-redirect refetch bubble.
//  Keeps saturating stall/flush event counters for the board displays.
// PARAMETERS
//  FWD_EN  1   1: forward from memory/wback stages; 0: stall until the producer retires
//  CNT_W   16  width of the stall/flush event counters
// PORTS
//  clock        in   1      pipeline clock (divided board clock)
//  reset        in   1      asynchronous, active-low reset
//  decode_ir    in   32     IR in decode stage
//  execute_ir   in   32     IR in execute stage
//  memory_ir    in   32     IR in memory stage
//  wback_ir     in   32     IR in wback stage
//  j_enable     in   1      jump resolved in execute this cycle
//  beq_enable   in   1      taken beq resolved in execute this cycle
//  pc_en        out  1      PC may advance (PC+1 or redirect target)
//  pc_load      out  1      PC takes redirect target this cycle
//  decode_en    out  1      decode_IR loads from instruction ROM
//  bubble_ex    out  1      execute_IR loads 32'b0 instead of decode_IR
//  flush_fd     out  1      zero decode_IR and execute_IR
//  fwd_a        out  2      rs operand select: 00 regfile, 01 mem_saidaULA, 10 wb_saidaULA
//  fwd_b        out  2      rt operand select, same encoding
//  ctrl_state   out  2      FSM state (debug / LEDG)
//  stall_cnt    out  CNT_W  stall cycles since reset, saturating
//  flush_cnt    out  CNT_W  redirects since reset, saturating
// BEHAVIOUR
//  Decode per IR: R-type (op 000000, funct 100000 add / 100010 sub) reads rs,rt, writes rd[15:11];
//   addi 001000 reads rs, writes rt[20:16]; lw 100011 reads rs, writes rt; sw 101011 reads rs,rt;
//   beq 000100 reads rs,rt; j 000010 and all other encodings read/write nothing. Dest $0 never matches.
//  FSM states: IDLE=0, REFILL=1, RUN=2. Registered state; all other outputs combinational from state+IRs.
//   IDLE: reset state. pc_en=0 decode_en=0 bubble_ex=1 flush_fd=0 pc_load=0. -> REFILL next clock.
//   REFILL: one-cycle ROM-latency bubble. pc_en=1 decode_en=0 bubble_ex=1. -> RUN.
//   RUN, priority order:
//    1) j_enable|beq_enable: pc_en=1 pc_load=1 flush_fd=1 decode_en=0; flush_cnt++; -> REFILL.
//    2) hazard: pc_en=0 decode_en=0 bubble_ex=1; stall_cnt++; stay RUN.
//    3) else pc_en=1 decode_en=1 bubble_ex=0.
//  Hazard (decode consumer vs producer): FWD_EN=1: execute_ir is lw and its dest matches a decode
//   source (1-cycle load-use). FWD_EN=0: dest of execute, memory or wback IR matches a decode source.
//  Forwarding (FWD_EN=1, consumer = execute_ir): per source, memory_ir dest match and memory_ir not lw
//   -> 01; else wback_ir dest match -> 10; else 00. Memory beats wback. FWD_EN=0: fwd_a=fwd_b=00.
//  Both j_enable and beq_enable high: treated as one redirect, flush_cnt +1.
//  Counters: +1 per qualifying cycle, hold at all-ones, cleared only by reset.
//  reset low at any time: state=IDLE, counters=0, outputs take IDLE values immediately (async).
//  Redirect flags in IDLE/REFILL are ignored (execute holds a bubble there by construction).
// STRUCTURE
//  Shared package mips_pipe_pkg: opcode/funct constants, FWD_RF/FWD_MEM/FWD_WB encodings,
//   FSM state encodings; reused by ula and jump_beq.
//  Sub-module instr_regs_decode (IR -> rs, rt, dest, uses_rs, uses_rt, writes, is_load),
//   instantiated four times, one per stage IR. Counters and FSM live in the top.
// TESTING
//  Reset: drive reset=0 while in RUN -> ctrl_state=0, pc_en=0, bubble_ex=1, counters 0; release ->
//   REFILL next clock (pc_en=1, decode_en=0), RUN the clock after.
//  Forward: memory_ir=0x00221820 (add $3,$1,$2), execute_ir=0x00612022 (sub $4,$3,$1) -> fwd_a=01,
//   fwd_b=00; same with add in wback_ir instead -> fwd_a=10.
//  Load-use: execute_ir=0x8C050000 (lw $5,0($0)), decode_ir=0x00A53020 (add $6,$5,$5) -> pc_en=0,
//   decode_en=0, bubble_ex=1, stall_cnt 0->1; next cycle execute_ir=0 -> no stall.
//  Redirect beats stall: load-use setup plus beq_enable=1 -> pc_load=1, flush_fd=1, stall_cnt
//   unchanged, flush_cnt +1, ctrl_state=REFILL next.
//  $0 / no-dest: memory_ir=0x20000005 (addi $0,$0,5), execute_ir reads $0 -> fwd_a=00, no stall;
//   memory_ir=sw or j -> never forwards.
//  FWD_EN=0 build: add $3 in wback_ir, consumer of $3 in decode -> stall; saturation: 2^CNT_W+3
//   stall cycles -> stall_cnt holds all-ones.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the 5-stage MIPS pipeline: opcodes, functs, forward selects, controller states.
package mips_pipe_pkg;

    localparam int unsigned IR_W  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RUN    = 2'd2
    } ctrl_state_e;

    // True when a consumer source register is produced by a writing stage.
    function automatic logic dest_match(input logic             use_src,
                                        input logic [REG_W-1:0] src,
                                        input logic             wr,
                                        input logic [REG_W-1:0] dst);
        return use_src && wr && (src == dst);
    endfunction

endpackage

// File: rtl/instr_regs_decode.sv
// Extracts register usage of one pipeline IR: sources read, destination written, load flag.
module instr_regs_decode
    import mips_pipe_pkg::*;
(
    input  logic [IR_W-1:0]  ir,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dest,
    output logic             uses_rs,
    output logic             uses_rt,
    output logic             writes,
    output logic             is_load
);

    logic unused_shamt;
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        rs      = ir[25:21];
        rt      = ir[20:16];
        dest    = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        writes  = 1'b0;
        is_load = 1'b0;
        case (ir[31:26])
            OP_RTYPE: begin
                if (ir[5:0] == FN_ADD || ir[5:0] == FN_SUB) begin
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                    writes  = 1'b1;
                    dest    = ir[15:11];
                end
            end
            OP_ADDI: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
                dest    = ir[20:16];
            end
            OP_LW: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
                is_load = 1'b1;
                dest    = ir[20:16];
            end
            OP_SW, OP_BEQ: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OP_J: ;
            default: ;
        endcase
        // Writes to $0 are discarded, so they never create a dependency.
        if (dest == '0) begin
            writes = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: restart/refetch FSM, load-use or full stalls, redirect flush,
// ALU operand forwarding and saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IR_W-1:0]  decode_ir,
    input  logic [IR_W-1:0]  execute_ir,
    input  logic [IR_W-1:0]  memory_ir,
    input  logic [IR_W-1:0]  wback_ir,
    input  logic             j_enable,
    input  logic             beq_enable,
    output logic             pc_en,
    output logic             pc_load,
    output logic             decode_en,
    output logic             bubble_ex,
    output logic             flush_fd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam bit USE_FWD = (FWD_EN != 0);

    logic [REG_W-1:0] d_rs, d_rt, d_dest, e_rs, e_rt, e_dest;
    logic [REG_W-1:0] m_rs, m_rt, m_dest, w_rs, w_rt, w_dest;
    logic d_ur, d_ut, d_w, d_load, e_ur, e_ut, e_w, e_load;
    logic m_ur, m_ut, m_w, m_load, w_ur, w_ut, w_w, w_load;

    instr_regs_decode u_dec_d (.ir(decode_ir),  .rs(d_rs), .rt(d_rt), .dest(d_dest),
                               .uses_rs(d_ur), .uses_rt(d_ut), .writes(d_w), .is_load(d_load));
    instr_regs_decode u_dec_e (.ir(execute_ir), .rs(e_rs), .rt(e_rt), .dest(e_dest),
                               .uses_rs(e_ur), .uses_rt(e_ut), .writes(e_w), .is_load(e_load));
    instr_regs_decode u_dec_m (.ir(memory_ir),  .rs(m_rs), .rt(m_rt), .dest(m_dest),
                               .uses_rs(m_ur), .uses_rt(m_ut), .writes(m_w), .is_load(m_load));
    instr_regs_decode u_dec_w (.ir(wback_ir),   .rs(w_rs), .rt(w_rt), .dest(w_dest),
                               .uses_rs(w_ur), .uses_rt(w_ut), .writes(w_w), .is_load(w_load));

    logic unused_dec;
    assign unused_dec = ^{d_dest, d_w, d_load, m_rs, m_rt, m_ur, m_ut,
                          w_rs, w_rt, w_ur, w_ut, w_load};

    // Decode-stage consumer against each downstream producer.
    logic ex_hit, mem_hit, wb_hit, hazard;
    assign ex_hit  = dest_match(d_ur, d_rs, e_w, e_dest) | dest_match(d_ut, d_rt, e_w, e_dest);
    assign mem_hit = dest_match(d_ur, d_rs, m_w, m_dest) | dest_match(d_ut, d_rt, m_w, m_dest);
    assign wb_hit  = dest_match(d_ur, d_rs, w_w, w_dest) | dest_match(d_ut, d_rt, w_w, w_dest);
    assign hazard  = USE_FWD ? (ex_hit && e_load) : (ex_hit || mem_hit || wb_hit);

    // A load in memory has no ALU result yet, so it yields to an older wback producer.
    function automatic logic [1:0] fwd_sel(input logic             use_src,
                                           input logic [REG_W-1:0] src,
                                           input logic             mw,
                                           input logic             mload,
                                           input logic [REG_W-1:0] mdst,
                                           input logic             ww,
                                           input logic [REG_W-1:0] wdst);
        if (dest_match(use_src, src, mw, mdst) && !mload) begin
            return FWD_MEM;
        end else if (dest_match(use_src, src, ww, wdst)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (USE_FWD) begin
            fwd_a = fwd_sel(e_ur, e_rs, m_w, m_load, m_dest, w_w, w_dest);
            fwd_b = fwd_sel(e_ut, e_rt, m_w, m_load, m_dest, w_w, w_dest);
        end
    end

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;

    // Next state and per-state pipeline controls; redirect outranks stall.
    always_comb begin
        state_d   = state_q;
        pc_en     = 1'b0;
        pc_load   = 1'b0;
        decode_en = 1'b0;
        bubble_ex = 1'b1;
        flush_fd  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REFILL;
            end
            ST_REFILL: begin
                pc_en   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (j_enable || beq_enable) begin
                    pc_en     = 1'b1;
                    pc_load   = 1'b1;
                    flush_fd  = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = ST_REFILL;
                end else if (hazard) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_en     = 1'b1;
                    decode_en = 1'b1;
                    bubble_ex = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctrl_state = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding build (CNT_W=16) and stall-only build (CNT_W=4)
// checked every cycle against a rule-level model, plus hand-computed spot values.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] ADD3   = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] SUB4   = 32'h00612022; // sub $4,$3,$1
    localparam logic [31:0] LW5    = 32'h8C050000; // lw  $5,0($0)
    localparam logic [31:0] ADD6   = 32'h00A53020; // add $6,$5,$5
    localparam logic [31:0] ADDI0  = 32'h20000005; // addi $0,$0,5
    localparam logic [31:0] ADD7_0 = 32'h00003820; // add $7,$0,$0
    localparam logic [31:0] SW3    = 32'hAC030000; // sw  $3,0($0)
    localparam logic [31:0] J3     = 32'h08000003; // j   3
    localparam logic [31:0] LW3    = 32'h8C030000; // lw  $3,0($0)

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] decode_ir = '0, execute_ir = '0, memory_ir = '0, wback_ir = '0;
    logic        j_enable = 1'b0, beq_enable = 1'b0;

    logic        pe0, pl0, de0, bx0, ff0, pe1, pl1, de1, bx1, ff1;
    logic [1:0]  fa0, fb0, cs0, fa1, fb1, cs1;
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) u_fwd (
        .clock(clock), .reset(reset), .decode_ir(decode_ir), .execute_ir(execute_ir),
        .memory_ir(memory_ir), .wback_ir(wback_ir), .j_enable(j_enable), .beq_enable(beq_enable),
        .pc_en(pe0), .pc_load(pl0), .decode_en(de0), .bubble_ex(bx0), .flush_fd(ff0),
        .fwd_a(fa0), .fwd_b(fb0), .ctrl_state(cs0), .stall_cnt(sc0), .flush_cnt(fc0));

    pipeline_hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u_nofwd (
        .clock(clock), .reset(reset), .decode_ir(decode_ir), .execute_ir(execute_ir),
        .memory_ir(memory_ir), .wback_ir(wback_ir), .j_enable(j_enable), .beq_enable(beq_enable),
        .pc_en(pe1), .pc_load(pl1), .decode_en(de1), .bubble_ex(bx1), .flush_fd(ff1),
        .fwd_a(fa1), .fwd_b(fb1), .ctrl_state(cs1), .stall_cnt(sc1), .flush_cnt(fc1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- rule-level model of the instruction set's register usage ----
    function automatic bit alu_r(input logic [31:0] ir);
        return ir[31:26] == 6'h00 && (ir[5:0] == 6'h20 || ir[5:0] == 6'h22);
    endfunction
    function automatic bit rd_rs(input logic [31:0] ir);
        return alu_r(ir) || ir[31:26] == 6'h08 || ir[31:26] == 6'h23 ||
               ir[31:26] == 6'h2B || ir[31:26] == 6'h04;
    endfunction
    function automatic bit rd_rt(input logic [31:0] ir);
        return alu_r(ir) || ir[31:26] == 6'h2B || ir[31:26] == 6'h04;
    endfunction
    // Register written, 0 meaning none (a $0 write is equivalent to none).
    function automatic int dst(input logic [31:0] ir);
        if (alu_r(ir)) return int'(ir[15:11]);
        if (ir[31:26] == 6'h08 || ir[31:26] == 6'h23) return int'(ir[20:16]);
        return 0;
    endfunction
    function automatic bit consumes(input logic [31:0] ir, input int r);
        return r != 0 && ((rd_rs(ir) && int'(ir[25:21]) == r) || (rd_rt(ir) && int'(ir[20:16]) == r));
    endfunction
    function automatic logic [1:0] fsel(input bit fwd, input bit rd, input int r);
        if (!fwd || !rd || r == 0) return 2'b00;
        if (dst(memory_ir) == r && memory_ir[31:26] != 6'h23) return 2'b01;
        if (dst(wback_ir) == r) return 2'b10;
        return 2'b00;
    endfunction

    // Phase 0 = post-reset, 1 = refetch bubble, 2 = running.
    task automatic model(input bit fwd, input int ph, output logic [10:0] ctl,
                         output int nph, output bit s_inc, output bit f_inc);
        bit pe, pl, de, bx, ff, hz;
        pe = 0; pl = 0; de = 0; bx = 1; ff = 0; s_inc = 0; f_inc = 0; nph = ph;
        if (fwd) hz = execute_ir[31:26] == 6'h23 && consumes(decode_ir, dst(execute_ir));
        else     hz = consumes(decode_ir, dst(execute_ir)) || consumes(decode_ir, dst(memory_ir)) ||
                      consumes(decode_ir, dst(wback_ir));
        if (ph == 0) nph = 1;
        else if (ph == 1) begin pe = 1; nph = 2; end
        else if (j_enable || beq_enable) begin pe = 1; pl = 1; ff = 1; f_inc = 1; nph = 1; end
        else if (hz) s_inc = 1;
        else begin pe = 1; de = 1; bx = 0; end
        ctl = {2'(ph), pe, pl, de, bx, ff,
               fsel(fwd, rd_rs(execute_ir), int'(execute_ir[25:21])),
               fsel(fwd, rd_rt(execute_ir), int'(execute_ir[20:16]))};
    endtask

    int mph[2] = '{0, 0};
    int msc[2] = '{0, 0};
    int mfc[2] = '{0, 0};

    // Per-cycle compare of both builds against the model; model advances on the clock edge.
    always begin
        int nph[2], nsc[2], nfc[2];
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            logic [10:0] ctl_e, ctl_a;
            int ph_n, cmax;
            bit si, fi;
            if (!reset) begin mph[k] = 0; msc[k] = 0; mfc[k] = 0; end
            model(k == 0, mph[k], ctl_e, ph_n, si, fi);
            cmax  = (k == 0) ? 65535 : 15;
            ctl_a = (k == 0) ? {cs0, pe0, pl0, de0, bx0, ff0, fa0, fb0}
                             : {cs1, pe1, pl1, de1, bx1, ff1, fa1, fb1};
            chk($sformatf("ctl[%0d]", k), 32'(ctl_a), 32'(ctl_e));
            chk($sformatf("stall_cnt[%0d]", k), (k == 0) ? 32'(sc0) : 32'(sc1), 32'(msc[k]));
            chk($sformatf("flush_cnt[%0d]", k), (k == 0) ? 32'(fc0) : 32'(fc1), 32'(mfc[k]));
            nph[k] = reset ? ph_n : 0;
            nsc[k] = (reset && si && msc[k] < cmax) ? msc[k] + 1 : msc[k];
            nfc[k] = (reset && fi && mfc[k] < cmax) ? mfc[k] + 1 : mfc[k];
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            mph[k] = nph[k]; msc[k] = nsc[k]; mfc[k] = nfc[k];
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask
    task automatic probe();
        @(negedge clock);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        probe();
        chk("rst_state", 32'(cs0), 32'd0);
        chk("rst_pc_en", 32'(pe0), 32'd0);
        chk("rst_bubble", 32'(bx0), 32'd1);
        chk("rst_stall_cnt", 32'(sc0), 32'd0);
        tick(); reset = 1'b1; probe();
        chk("idle_hold", 32'(cs0), 32'd0);
        tick(); probe();
        chk("refill_state", 32'(cs0), 32'd1);
        chk("refill_pc_en", 32'(pe0), 32'd1);
        chk("refill_decode_en", 32'(de0), 32'd0);
        tick(); probe();
        chk("run_state", 32'(cs0), 32'd2);
        chk("run_decode_en", 32'(de0), 32'd1);

        tick(); memory_ir = ADD3; execute_ir = SUB4; probe();
        chk("fwd_a_mem", 32'(fa0), 32'd1);
        chk("fwd_b_rf", 32'(fb0), 32'd0);
        tick(); memory_ir = '0; wback_ir = ADD3; probe();
        chk("fwd_a_wb", 32'(fa0), 32'd2);

        tick(); wback_ir = '0; execute_ir = LW5; decode_ir = ADD6; probe();
        chk("lu_pc_en", 32'(pe0), 32'd0);
        chk("lu_decode_en", 32'(de0), 32'd0);
        chk("lu_bubble", 32'(bx0), 32'd1);
        chk("lu_stall_before", 32'(sc0), 32'd0);
        tick(); execute_ir = '0; probe();
        chk("lu_released", 32'(pe0), 32'd1);
        chk("lu_stall_after", 32'(sc0), 32'd1);

        tick(); execute_ir = LW5; beq_enable = 1'b1; probe();
        chk("redir_pc_load", 32'(pl0), 32'd1);
        chk("redir_flush", 32'(ff0), 32'd1);
        tick(); beq_enable = 1'b0; execute_ir = '0; decode_ir = '0; probe();
        chk("redir_refill", 32'(cs0), 32'd1);
        chk("redir_stall_kept", 32'(sc0), 32'd1);
        chk("redir_flush_cnt", 32'(fc0), 32'd1);
        tick(); probe();
        tick(); j_enable = 1'b1; beq_enable = 1'b1; probe();
        tick(); j_enable = 1'b0; beq_enable = 1'b0; probe();
        chk("dual_redir_cnt", 32'(fc0), 32'd2);

        tick(); memory_ir = ADDI0; execute_ir = ADD7_0; probe();
        chk("r0_no_fwd", 32'(fa0), 32'd0);
        chk("r0_no_stall", 32'(pe0), 32'd1);
        tick(); memory_ir = SW3; execute_ir = SUB4; probe();
        chk("sw_no_fwd", 32'(fa0), 32'd0);
        tick(); memory_ir = J3; probe();
        chk("j_no_fwd", 32'(fa0), 32'd0);
        tick(); memory_ir = LW3; probe();
        chk("mem_lw_no_fwd", 32'(fa0), 32'd0);
        tick(); wback_ir = ADD3; probe();
        chk("mem_lw_wb_fwd", 32'(fa0), 32'd2);

        tick(); memory_ir = '0; wback_ir = '0; execute_ir = '0;
        @(negedge clock); #1; reset = 1'b0; #1;
        chk("async_state", 32'(cs0), 32'd0);
        chk("async_pc_en", 32'(pe0), 32'd0);
        chk("async_bubble", 32'(bx0), 32'd1);
        chk("async_stall_cnt", 32'(sc0), 32'd0);
        chk("async_flush_cnt", 32'(fc0), 32'd0);
        tick(); tick(); reset = 1'b1; probe();
        tick(); probe();
        chk("rerun_refill", 32'(cs0), 32'd1);
        tick(); probe();
        chk("rerun_run", 32'(cs0), 32'd2);

        tick(); wback_ir = ADD3; decode_ir = SUB4; probe();
        chk("nofwd_stall", 32'(pe1), 32'd0);
        chk("fwd_no_stall", 32'(pe0), 32'd1);
        repeat (14) tick();
        probe();
        chk("sat_below", 32'(sc1), 32'd14);
        repeat (4) tick();
        probe();
        chk("sat_hold", 32'(sc1), 32'd15);
        chk("fwd_stall_zero", 32'(sc0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
